// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder, its requester and the benches around them.
package serial_add_pkg;

    localparam int unsigned SA_WIDTH     = 16;
    localparam int unsigned SA_TIMEOUT   = 64;
    localparam int unsigned SA_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sar_state_t;

    typedef struct packed {
        logic mismatch;
        logic timeout;
    } sar_status_t;

    function automatic logic sar_is_error(input sar_status_t status);
        return status.mismatch | status.timeout;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter16
    import serial_add_pkg::*;
(
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    inc,
    output logic [SA_CNT_WIDTH-1:0] count
);

    localparam int unsigned CW = SA_CNT_WIDTH;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/serial_add_requester.sv
// Initiator for the serial adder start/done handshake: issues one operand pair,
// waits for done or a timeout, checks the sum and returns it over a response port.
module serial_add_requester
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH   = SA_WIDTH,
    parameter int unsigned TIMEOUT = SA_TIMEOUT,
    parameter bit          CHECK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WIDTH-1:0]        req_a,
    input  logic [WIDTH-1:0]        req_b,
    output logic                    add_start,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_mismatch,
    output logic                    rsp_timeout,
    output logic [SA_CNT_WIDTH-1:0] txn_count,
    output logic [SA_CNT_WIDTH-1:0] err_count
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    sar_state_t       state_q;
    logic [TW-1:0]    timer_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic             add_start_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_sum_q;
    sar_status_t      rsp_status_q;

    logic [WIDTH-1:0] golden_c;
    logic             timer_expired_c;
    logic             rsp_fire_c;
    logic             rsp_err_fire_c;

    // Golden sum keeps only the low WIDTH bits; the carry-out is not part of the result.
    assign golden_c        = add_a_q + add_b_q;
    assign timer_expired_c = (timer_q == TW'(TIMEOUT - 1));
    assign rsp_fire_c      = (state_q == RESP) && rsp_ready;
    assign rsp_err_fire_c  = rsp_fire_c && sar_is_error(rsp_status_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_status_q <= '0;
        end else begin
            add_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        add_a_q     <= req_a;
                        add_b_q     <= req_b;
                        add_start_q <= 1'b1;
                        state_q     <= START;
                    end
                end
                // The adder may still present done from the previous operation here.
                START: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (add_done) begin
                        rsp_sum_q             <= add_sum;
                        rsp_status_q.mismatch <= CHECK && (add_sum != golden_c);
                        rsp_status_q.timeout  <= 1'b0;
                        rsp_valid_q           <= 1'b1;
                        state_q               <= RESP;
                    end else if (timer_expired_c) begin
                        rsp_sum_q             <= '0;
                        rsp_status_q.mismatch <= 1'b0;
                        rsp_status_q.timeout  <= 1'b1;
                        rsp_valid_q           <= 1'b1;
                        state_q               <= RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter16 u_txn_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (rsp_fire_c),
        .count (txn_count)
    );

    sat_counter16 u_err_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (rsp_err_fire_c),
        .count (err_count)
    );

    assign req_ready    = (state_q == IDLE) && !reset;
    assign add_start    = add_start_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_sum      = rsp_sum_q;
    assign rsp_mismatch = rsp_status_q.mismatch;
    assign rsp_timeout  = rsp_status_q.timeout;

endmodule

// File: tb/tb_serial_add_requester.sv
// Bench for serial_add_requester: behavioural adder with programmable latency/corruption,
// transaction-level reference model, and a CHECK=0 twin sharing all inputs.
module tb_serial_add_requester;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         add_start;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_sum;
    logic         add_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_mismatch;
    logic         rsp_timeout;
    logic [15:0]  txn_count;
    logic [15:0]  err_count;

    logic         d1_req_ready;
    logic         d1_add_start;
    logic [W-1:0] d1_add_a;
    logic [W-1:0] d1_add_b;
    logic         d1_rsp_valid;
    logic [W-1:0] d1_rsp_sum;
    logic         d1_rsp_mismatch;
    logic         d1_rsp_timeout;
    logic [15:0]  d1_txn_count;
    logic [15:0]  d1_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_requester #(.WIDTH(W), .TIMEOUT(TO), .CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .add_done(add_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
        .txn_count(txn_count), .err_count(err_count)
    );

    serial_add_requester #(.WIDTH(W), .TIMEOUT(TO), .CHECK(1'b0)) dut_nochk (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(d1_req_ready), .req_a(req_a), .req_b(req_b),
        .add_start(d1_add_start), .add_a(d1_add_a), .add_b(d1_add_b),
        .add_sum(add_sum), .add_done(add_done),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(d1_rsp_sum),
        .rsp_mismatch(d1_rsp_mismatch), .rsp_timeout(d1_rsp_timeout),
        .txn_count(d1_txn_count), .err_count(d1_err_count)
    );

    // Behavioural adder: mode 0 correct, 1 result XOR mask, 2 never done.
    int           cfg_mode   = 0;
    int           cfg_lat    = 1;
    bit           cfg_sticky = 1'b0;
    logic [W-1:0] cfg_mask   = '0;

    bit           ad_busy;
    bit           ad_sticky;
    int           ad_rem;
    logic [W-1:0] ad_pend;

    always @(posedge clk) begin
        if (reset) begin
            ad_busy   <= 1'b0;
            ad_sticky <= 1'b0;
            ad_rem    <= 0;
            ad_pend   <= '0;
            add_done  <= 1'b0;
            add_sum   <= '0;
        end else if (add_start) begin
            ad_busy   <= (cfg_mode != 2);
            ad_sticky <= cfg_sticky;
            ad_rem    <= cfg_lat - 1;
            ad_pend   <= (add_a + add_b) ^ ((cfg_mode == 1) ? cfg_mask : '0);
            if (cfg_mode != 2 && cfg_lat == 1) begin
                add_done <= 1'b1;
                add_sum  <= (add_a + add_b) ^ ((cfg_mode == 1) ? cfg_mask : '0);
            end else begin
                add_done <= 1'b0;
            end
        end else if (ad_busy) begin
            if (add_done) begin
                if (!ad_sticky) begin
                    add_done <= 1'b0;
                    ad_busy  <= 1'b0;
                end
            end else if (ad_rem <= 1) begin
                add_done <= 1'b1;
                add_sum  <= ad_pend;
            end else begin
                ad_rem <= ad_rem - 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference statistics
    int txn_m  = 0;
    int err_m  = 0;
    int err1_m = 0;

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                           input int lat, input bit sticky, input logic [W-1:0] mask,
                           input int hold);
        int           full;
        logic [W-1:0] golden;
        logic [W-1:0] out_v;
        logic [W-1:0] exp_sum;
        bit           done_ok;
        bit           exp_mm;
        int           exp_lat;
        int           n;
        bit           start_again;
        bit           held_ok;
        bit           stable;
        bit           ignored;
        logic [W-1:0] s_sum;
        logic         s_mm;
        logic         s_to;

        full    = (int'(a) + int'(b)) % 65536;
        golden  = W'(full);
        out_v   = (mode == 1) ? (golden ^ mask) : golden;
        done_ok = (mode != 2) && (lat <= int'(TO));
        exp_sum = done_ok ? out_v : '0;
        exp_mm  = done_ok && (out_v != golden);
        exp_lat = done_ok ? lat + 1 : int'(TO) + 1;

        cfg_mode   = mode;
        cfg_lat    = lat;
        cfg_sticky = sticky;
        cfg_mask   = mask;

        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("add_start_pulse", 32'(add_start), 32'd1);
        check_eq("add_operands", {add_a, add_b}, {a, b});
        check_eq("nochk_add_start", {15'd0, d1_add_start, d1_add_a}, {15'd0, 1'b1, a});
        check_eq("nochk_add_b", 32'(d1_add_b), 32'(b));

        n           = 0;
        start_again = 1'b0;
        held_ok     = 1'b1;
        while (!rsp_valid && n < int'(TO) + 10) begin
            @(posedge clk); #1;
            n++;
            if (add_start) start_again = 1'b1;
            if (!rsp_valid && (add_a != a || add_b != b)) held_ok = 1'b0;
        end
        check_eq("add_start_single", 32'(start_again), 32'd0);
        check_eq("operands_held", 32'(held_ok), 32'd1);
        check_eq("rsp_latency", 32'(n), 32'(exp_lat));
        check_eq("rsp_sum", 32'(rsp_sum), 32'(exp_sum));
        check_eq("rsp_mismatch", 32'(rsp_mismatch), 32'(exp_mm));
        check_eq("rsp_timeout", 32'(rsp_timeout), 32'(!done_ok));
        check_eq("req_ready_busy", 32'(req_ready), 32'd0);
        check_eq("nochk_rsp", {d1_rsp_valid, d1_rsp_mismatch, d1_rsp_timeout, d1_rsp_sum},
                 {1'b1, 1'b0, !done_ok, exp_sum});

        s_sum   = rsp_sum;
        s_mm    = rsp_mismatch;
        s_to    = rsp_timeout;
        stable  = 1'b1;
        ignored = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_a     = W'($urandom);
            req_b     = W'($urandom);
            @(posedge clk); #1;
            if (!rsp_valid || rsp_sum != s_sum || rsp_mismatch != s_mm || rsp_timeout != s_to)
                stable = 1'b0;
            if (req_ready || add_start) ignored = 1'b0;
        end
        req_valid = 1'b0;
        if (hold > 0) begin
            check_eq("rsp_stable_hold", 32'(stable), 32'd1);
            check_eq("req_ignored_hold", 32'(ignored), 32'd1);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        txn_m = sat_inc(txn_m);
        if (exp_mm || !done_ok) err_m = sat_inc(err_m);
        if (!done_ok) err1_m = sat_inc(err1_m);
        check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check_eq("txn_count", 32'(txn_count), 32'(txn_m));
        check_eq("err_count", 32'(err_count), 32'(err_m));
        check_eq("nochk_txn_count", 32'(d1_txn_count), 32'(txn_m));
        check_eq("nochk_err_count", 32'(d1_err_count), 32'(err1_m));
        check_eq("req_ready_back", {30'd0, req_ready, d1_req_ready}, 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_req_ready", 32'(req_ready), 32'd0);
        check_eq("reset_add_start", 32'(add_start), 32'd0);
        check_eq("reset_add_ops", {add_a, add_b}, 32'd0);
        check_eq("reset_rsp", {13'd0, rsp_valid, rsp_mismatch, rsp_timeout, rsp_sum}, 32'd0);
        check_eq("reset_counters", {txn_count, err_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_txn(16'h1234, 16'h5678, 0, 17, 1'b0, '0, 0);
        run_txn(16'hFFFF, 16'h0001, 0, 17, 1'b0, '0, 0);
        run_txn(16'h8000, 16'h8000, 0, 17, 1'b0, '0, 0);
        run_txn(16'h00AA, 16'h0055, 2, 1, 1'b0, '0, 0);
        run_txn(16'h0001, 16'h0001, 1, 5, 1'b0, 16'h0001, 0);
        run_txn(16'h4321, 16'h1111, 0, 9, 1'b0, '0, 5);
        run_txn(16'h1111, 16'h2222, 0, 3, 1'b1, '0, 0);
        run_txn(16'h0100, 16'h0200, 0, 5, 1'b0, '0, 0);
        run_txn(16'h0F0F, 16'h0101, 0, 1, 1'b0, '0, 0);
        run_txn(16'h7777, 16'h1000, 0, int'(TO), 1'b0, '0, 0);
        run_txn(16'h7777, 16'h2000, 0, int'(TO) + 1, 1'b0, '0, 0);

        // Reset while waiting on the adder
        cfg_mode  = 2;
        req_a     = 16'hDEAD;
        req_b     = 16'hBEEF;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midreset_add_start", 32'(add_start), 32'd0);
        check_eq("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("midreset_counters", {txn_count, err_count}, 32'd0);
        check_eq("midreset_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("midreset_idle", 32'(req_ready), 32'd1);
        txn_m  = 0;
        err_m  = 0;
        err1_m = 0;
        run_txn(16'h0002, 16'h0003, 0, 17, 1'b0, '0, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int           r;
            int           mode;
            int           lat;
            logic [W-1:0] mask;
            r    = int'($urandom_range(0, 9));
            mode = (r <= 6) ? 0 : ((r <= 8) ? 1 : 2);
            lat  = int'($urandom_range(1, W + 2));
            if ($urandom_range(0, 9) == 0) lat = int'(TO) + int'($urandom_range(0, 1));
            mask = W'($urandom_range(1, 65535));
            run_txn(W'($urandom), W'($urandom), mode, lat, 1'($urandom_range(0, 1)), mask,
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_requester.md
# serial_add_requester

Initiator for the 16-bit serial adder's start/done interface. It accepts operand pairs over a valid/ready request port and drives `start`/`A`/`B` into the adder. It waits for `done`, captures `Sum`, checks it against a golden A+B and returns the result over a valid/ready response port. It sits between the operand source (bench sequencer or CPU-side register block) and `serial_adder`, and replaces the ad-hoc start/wait(done) sequencing the benches do by hand.

## Interface
- `WIDTH`, 16: operand/sum width; must match the adder.
- `TIMEOUT`, 64: maximum cycles in WAIT before declaring a timeout; ≥ WIDTH+2.
- `CHECK`, 1: 1 enables golden-sum comparison; 0 forces `rsp_mismatch`=0.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1, `req_ready` out 1, `req_a` in WIDTH, `req_b` in WIDTH: operand request.
- `add_start` out 1, `add_a` out WIDTH, `add_b` out WIDTH: to adder `start`/`A`/`B`.
- `add_sum` in WIDTH, `add_done` in 1: from adder `Sum`/`done`.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_sum` out WIDTH: response.
- `rsp_mismatch` out 1, `rsp_timeout` out 1: response status.
- `txn_count` out 16, `err_count` out 16: saturating statistics.

## Operation
- FSM states: IDLE, START, WAIT, RESP. Reset places the FSM in IDLE.
- Reset values: `add_start`=0, `add_a`=`add_b`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_mismatch`=0, `rsp_timeout`=0, counters=0. `req_ready`=0 while `reset` is high.
- IDLE: `req_ready`=1. When `req_valid&&req_ready`, latch `req_a`/`req_b` into `add_a`/`add_b` and go to START.
- START: `add_start`=1 for exactly one cycle. `add_done` is ignored in this cycle because the adder may still be showing a stale done. Clear the timer and go to WAIT.
- WAIT: the timer increments each cycle. `add_a`/`add_b` are held stable from START through the end of WAIT.
  - `add_done`=1: capture `add_sum` into `rsp_sum`. Set `rsp_mismatch` = CHECK && (`add_sum` != (`add_a`+`add_b`) mod 2^WIDTH), with the carry-out discarded. Set `rsp_timeout`=0. Go to RESP.
  - Timer reaches TIMEOUT-1 with no done: `rsp_sum`=0, `rsp_timeout`=1, `rsp_mismatch`=0. Go to RESP.
  - `add_done` in the same cycle the timer expires: done wins, no timeout.
- RESP: `rsp_valid`=1. All `rsp_*` outputs are held stable until `rsp_ready`. On handshake:
  - `txn_count`++.
  - `err_count`++ if mismatch or timeout.
  - Both counters saturate at 16'hFFFF.
  - Go to IDLE.
- Only one transaction is in flight. `req_ready`=0 in START/WAIT/RESP.
- Reset mid-operation (any state): at the next edge return to IDLE, `add_start`=0, drop the pending response, clear counters. The adder shares `reset` and aborts too.

## Timing
- Request accepted at edge T.
- `add_start` is high during cycle T+1 only.
- If `add_done` is first sampled high at edge T+1+k (k≥1), `rsp_valid` rises after that edge. Overhead beyond the adder's latency is 2 cycles.
- Minimum request-to-request spacing is k+3 cycles with `rsp_ready` tied high. Back-to-back acceptance is not supported.
- `req_ready` and `rsp_valid` are decoded from registered state only. There is no combinational path from `req_valid`/`rsp_ready`/`add_done` to any output.

## Structure
- Shared package `serial_add_pkg`:
  - state enum `sar_state_t` (IDLE/START/WAIT/RESP)
  - `SA_WIDTH`=16 and `SA_TIMEOUT`=64 constants, shared with `serial_adder` and benches
- One sub-module, `sat_counter16`: 16-bit counter with `inc`/`clr` inputs that holds at 16'hFFFF. It is instantiated twice.
- Expected size: ~150–250 lines RTL.

## Test plan
- 16'h1234+16'h5678 with the real `serial_adder`: rsp_sum=16'h68AC, mismatch=0, timeout=0, txn_count=1, err_count=0.
- 16'hFFFF+16'h0001: rsp_sum=16'h0000, mismatch=0 (carry discarded). Then 16'h8000+16'h8000 gives 16'h0000, mismatch=0.
- Stub adder that never asserts done: rsp_valid rises TIMEOUT cycles after add_start, rsp_timeout=1, rsp_sum=0, err_count=1.
- Stub returning 16'h0003 for 16'h0001+16'h0001: rsp_mismatch=1, err_count=1. Repeat with CHECK=0: mismatch=0, err_count=0.
- rsp_ready held low 5 cycles in RESP: rsp_* stable, req_ready=0, req_valid ignored. Accept proceeds only after the handshake.
- Reset asserted mid-WAIT: next cycle FSM in IDLE, add_start=0, rsp_valid=0, counters=0. A following 16'h0002+16'h0003 request returns 16'h0005.
